// File: rtl/ste_btn_debounce.sv
`default_nettype none
// ste_btn_debounce: synchronizes and debounces a push-button, giving a level and a one-cycle press pulse.
// Optional auto-repeat while held is compiled in by defining STE_BTN_AUTOREPEAT_EN.  Rev 1.0
module ste_btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
`ifdef STE_BTN_AUTOREPEAT_EN
  ,
  parameter logic [23:0] REPEAT_CYCLES   = 24'd10_000_000
`endif
) (
  input  logic clk,
  input  logic reset_ni,
  input  logic btn_i,
  output logic trig_pls,
  output logic btn_level_o
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  localparam logic [19:0] DEB_LAST = DEBOUNCE_CYCLES - 20'd1;

  logic        sync1_q;
  logic        btn_sync_q;
  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        trig_q, trig_d;
  logic        level_q, level_d;

`ifdef STE_BTN_AUTOREPEAT_EN
  localparam logic [23:0] REP_LAST = REPEAT_CYCLES - 24'd1;
  logic [23:0] rep_q, rep_d;
`endif

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1_q    <= 1'b0;
      btn_sync_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= 20'd0;
      trig_q     <= 1'b0;
      level_q    <= 1'b0;
    end else begin
      sync1_q    <= btn_i;
      btn_sync_q <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      trig_q     <= trig_d;
      level_q    <= level_d;
    end
  end

`ifdef STE_BTN_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      rep_q <= 24'd0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trig_d  = 1'b0;
    level_d = level_q;
`ifdef STE_BTN_AUTOREPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (btn_sync_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = 20'd0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync_q) begin
          state_d = IDLE;
          cnt_d   = 20'd0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          cnt_d   = 20'd0;
          trig_d  = 1'b1;
          level_d = 1'b1;
`ifdef STE_BTN_AUTOREPEAT_EN
          rep_d   = 24'd0;
`endif
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      HELD: begin
        if (!btn_sync_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = 20'd0;
`ifdef STE_BTN_AUTOREPEAT_EN
          rep_d   = 24'd0;
`endif
        end
`ifdef STE_BTN_AUTOREPEAT_EN
        // Repeat only while the button is still seen held; a release sample takes priority.
        else if (rep_q == REP_LAST) begin
          rep_d  = 24'd0;
          trig_d = 1'b1;
        end else begin
          rep_d = rep_q + 24'd1;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (btn_sync_q) begin
          state_d = HELD;
          cnt_d   = 20'd0;
`ifdef STE_BTN_AUTOREPEAT_EN
          rep_d   = 24'd0;
`endif
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = 20'd0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 20'd0;
      end
    endcase
  end

  assign trig_pls    = trig_q;
  assign btn_level_o = level_q;

endmodule
`default_nettype wire

// File: tb/tb_ste_btn_debounce.sv
`default_nettype none
// Self-checking bench for ste_btn_debounce (DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32) against a run-length reference model.
module tb_ste_btn_debounce;

  localparam int D = 8;
  localparam int R = 32;
`ifdef STE_BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_ni;
  logic btn_i;
  logic trig_pls;
  logic btn_level_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: samples delayed two edges; the level flips after D+1 consecutive
  // opposite samples; repeat pulses every R uninterrupted held samples.
  logic [1:0] hist;
  logic       m_level;
  logic       m_trig;
  int         run;
  int         rep;

  ste_btn_debounce #(
    .DEBOUNCE_CYCLES(20'd8)
`ifdef STE_BTN_AUTOREPEAT_EN
    , .REPEAT_CYCLES(24'd32)
`endif
  ) dut (
    .clk        (clk),
    .reset_ni   (reset_ni),
    .btn_i      (btn_i),
    .trig_pls   (trig_pls),
    .btn_level_o(btn_level_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    hist    = 2'b00;
    m_level = 1'b0;
    m_trig  = 1'b0;
    run     = 0;
    rep     = 0;
  endtask

  task automatic model_step();
    logic seen;
    seen    = hist[1];
    hist[1] = hist[0];
    hist[0] = btn_i;
    m_trig  = 1'b0;
    if (!m_level) begin
      if (seen) begin
        run++;
        if (run == D + 1) begin
          m_level = 1'b1;
          m_trig  = 1'b1;
          run     = 0;
          rep     = 0;
        end
      end else begin
        run = 0;
      end
    end else begin
      if (!seen) begin
        run++;
        rep = 0;
        if (run == D + 1) begin
          m_level = 1'b0;
          run     = 0;
        end
      end else begin
        if (run > 0) begin
          rep = 0;
        end else begin
          rep++;
          if (AR && rep == R) begin
            m_trig = 1'b1;
            rep    = 0;
          end
        end
        run = 0;
      end
    end
  endtask

  task automatic drive(input logic b);
    btn_i = b;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0);
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    btn_i    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (trig_pls !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_trig: got %b, expected 0", trig_pls);
    end
    n_tests++;
    if (btn_level_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_level: got %b, expected 0", btn_level_o);
    end
    reset_ni = 1'b1;
    settle(4);
  endtask

  task automatic test_clean_press();
    int np, first, fall;
    np = 0; first = -1; fall = -1;
    for (int i = 1; i <= 40; i++) begin
      drive(1'b1);
      n_tests++;
      if (trig_pls !== m_trig || btn_level_o !== m_level) begin
        n_fail++;
        $display("FAIL clean_press cyc %0d: trig=%b level=%b, expected trig=%b level=%b", i, trig_pls, btn_level_o, m_trig, m_level);
      end
      if (trig_pls === 1'b1) begin
        np++;
        if (first < 0) first = i;
      end
    end
    n_tests++;
    if (np != 1 || first != 11) begin
      n_fail++;
      $display("FAIL clean_press_pulse: %0d pulses first at edge %0d, expected 1 at edge 11", np, first);
    end
    n_tests++;
    if (btn_level_o !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_press_level: got %b, expected 1", btn_level_o);
    end
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0);
      n_tests++;
      if (trig_pls !== m_trig || btn_level_o !== m_level) begin
        n_fail++;
        $display("FAIL clean_release cyc %0d: trig=%b level=%b, expected trig=%b level=%b", i, trig_pls, btn_level_o, m_trig, m_level);
      end
      if (btn_level_o === 1'b0 && fall < 0) fall = i;
    end
    n_tests++;
    if (fall != 11) begin
      n_fail++;
      $display("FAIL release_latency: level fell at edge %0d, expected 11", fall);
    end
  endtask

  task automatic test_bounce();
    int np, first;
    logic b;
    np = 0; first = -1;
    settle(14);
    for (int i = 1; i <= 50; i++) begin
      b = (i > 30) ? 1'b1 : (((i - 1) / 3) % 2 == 0);
      drive(b);
      n_tests++;
      if (trig_pls !== m_trig || btn_level_o !== m_level) begin
        n_fail++;
        $display("FAIL bounce cyc %0d: trig=%b level=%b, expected trig=%b level=%b", i, trig_pls, btn_level_o, m_trig, m_level);
      end
      if (trig_pls === 1'b1) begin
        np++;
        if (first < 0) first = i;
      end
    end
    n_tests++;
    if (np != 1 || first != 41) begin
      n_fail++;
      $display("FAIL bounce_pulse: %0d pulses first at edge %0d, expected 1 at edge 41", np, first);
    end
    settle(14);
  endtask

  task automatic test_glitch();
    int np, nl;
    np = 0; nl = 0;
    settle(14);
    for (int i = 1; i <= 25; i++) begin
      drive(i <= 5);
      n_tests++;
      if (trig_pls !== m_trig || btn_level_o !== m_level) begin
        n_fail++;
        $display("FAIL glitch cyc %0d: trig=%b level=%b, expected trig=%b level=%b", i, trig_pls, btn_level_o, m_trig, m_level);
      end
      if (trig_pls !== 1'b0) np++;
      if (btn_level_o !== 1'b0) nl++;
    end
    n_tests++;
    if (np != 0 || nl != 0) begin
      n_fail++;
      $display("FAIL glitch_quiet: %0d pulse cycles %0d high-level cycles, expected 0 and 0", np, nl);
    end
  endtask

  task automatic test_release_bounce();
    int np, low, fall;
    np = 0; low = 0; fall = -1;
    settle(14);
    for (int i = 1; i <= 15; i++) drive(1'b1);
    for (int i = 1; i <= 20; i++) begin
      drive(!(i <= 4));
      n_tests++;
      if (trig_pls !== m_trig || btn_level_o !== m_level) begin
        n_fail++;
        $display("FAIL release_bounce cyc %0d: trig=%b level=%b, expected trig=%b level=%b", i, trig_pls, btn_level_o, m_trig, m_level);
      end
      if (trig_pls !== 1'b0) np++;
      if (btn_level_o !== 1'b1) low++;
    end
    n_tests++;
    if (np != 0 || low != 0) begin
      n_fail++;
      $display("FAIL release_bounce_hold: %0d pulses %0d low-level cycles, expected 0 and 0", np, low);
    end
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0);
      if (btn_level_o === 1'b0 && fall < 0) fall = i;
    end
    n_tests++;
    if (fall != 11) begin
      n_fail++;
      $display("FAIL final_release: level fell at edge %0d, expected 11", fall);
    end
  endtask

  task automatic test_reset_mid_press();
    int first;
    first = -1;
    settle(14);
    for (int i = 1; i <= 8; i++) drive(1'b1);
    reset_ni = 1'b0;
    #1;
    n_tests++;
    if (trig_pls !== 1'b0 || btn_level_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_press: trig=%b level=%b, expected 0 0", trig_pls, btn_level_o);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_ni = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      drive(1'b1);
      n_tests++;
      if (trig_pls !== m_trig || btn_level_o !== m_level) begin
        n_fail++;
        $display("FAIL reset_repress cyc %0d: trig=%b level=%b, expected trig=%b level=%b", i, trig_pls, btn_level_o, m_trig, m_level);
      end
      if (trig_pls === 1'b1 && first < 0) first = i;
    end
    n_tests++;
    if (first != 11) begin
      n_fail++;
      $display("FAIL reset_repress_pulse: first pulse at edge %0d, expected 11", first);
    end
    reset_ni = 1'b0;
    #1;
    n_tests++;
    if (btn_level_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_held: level=%b, expected 0 immediately", btn_level_o);
    end
    model_reset();
    #2;
    reset_ni = 1'b1;
    settle(14);
  endtask

  task automatic test_autorepeat();
    int np;
    int edges[4];
    np = 0;
    settle(14);
    for (int i = 1; i <= 120; i++) begin
      drive(1'b1);
      n_tests++;
      if (trig_pls !== m_trig || btn_level_o !== m_level) begin
        n_fail++;
        $display("FAIL autorepeat cyc %0d: trig=%b level=%b, expected trig=%b level=%b", i, trig_pls, btn_level_o, m_trig, m_level);
      end
      if (trig_pls === 1'b1) begin
        if (np < 4) edges[np] = i;
        np++;
      end
    end
    n_tests++;
    if (AR ? (np != 4 || edges[0] != 11 || edges[1] != 43 || edges[2] != 75 || edges[3] != 107)
           : (np != 1 || edges[0] != 11)) begin
      n_fail++;
      $display("FAIL autorepeat_pulses: %0d pulses first at edge %0d, expected %0d pulses from edge 11", np, (np > 0) ? edges[0] : -1, AR ? 4 : 1);
    end
    settle(14);
  endtask

  task automatic test_random();
    int   cyc, len;
    logic lvl, prev;
    cyc = 0; lvl = 1'b0; prev = 1'b0;
    while (cyc < 800) begin
      len = $urandom_range(1, 14);
      lvl = ~lvl;
      for (int k = 0; k < len; k++) begin
        drive(lvl);
        cyc++;
        n_tests++;
        if (trig_pls !== m_trig || btn_level_o !== m_level) begin
          n_fail++;
          $display("FAIL random cyc %0d: trig=%b level=%b, expected trig=%b level=%b", cyc, trig_pls, btn_level_o, m_trig, m_level);
        end
        n_tests++;
        if (prev === 1'b1 && trig_pls === 1'b1) begin
          n_fail++;
          $display("FAIL random_adjacent cyc %0d: trig=1 after trig=1, expected 0", cyc);
        end
        prev = trig_pls;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_release_bounce();
    test_reset_mid_press();
    test_autorepeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
